// File: rtl/spi_register_loader.sv
// spi_register_loader: deserializes SPI mode-0 frames (16-bit register number,
// 8-bit value, MSB first) into a write FIFO and drains queued writes onto the
// synth register-write port, at most one per clock, unless held.
//
// Ports:
//   i_Clock, i_Reset         system clock, synchronous active-high reset
//   i_SpiSclk/Mosi/CsN       raw SPI pins (asynchronous to i_Clock)
//   i_WriteHold              blocks draining while high
//   o_RegisterWrite*         one-cycle write strobe with number/value
//   o_FifoLevel              queued entry count
//   o_Overflow, o_FrameError sticky error flags, cleared by reset only
module spi_register_loader #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                              i_Clock,
    input  logic                              i_Reset,
    input  logic                              i_SpiSclk,
    input  logic                              i_SpiMosi,
    input  logic                              i_SpiCsN,
    input  logic                              i_WriteHold,
    output logic                              o_RegisterWriteEnable,
    output logic [15:0]                       o_RegisterWriteNumber,
    output logic [7:0]                        o_RegisterWriteValue,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_FifoLevel,
    output logic                              o_Overflow,
    output logic                              o_FrameError
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned FRAME_W = 24;
    localparam int unsigned CNT_W   = 5;

    typedef struct packed {
        logic [15:0] number;
        logic [7:0]  value;
    } reg_write_t;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] csn_sync;
    logic                   sclk_prev;
    logic                   csn_prev;

    logic [CNT_W-1:0]       bit_cnt;
    // Holds the 23 previously received bits; the 24th is taken straight from
    // the synchronized MOSI so the frame can be pushed in the completing cycle.
    logic [FRAME_W-2:0]     shift_reg;

    reg_write_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;

    logic                   sclk_s, mosi_s, csn_s;
    logic                   sclk_rise_c, csn_rise_c;
    logic [FRAME_W-1:0]     frame_bits_c;
    reg_write_t             frame_c;
    logic                   push_c, push_ok_c, pop_c, full_c;

    // Input synchronizers, reset to idle bus values
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            csn_sync  <= '1;
            sclk_prev <= 1'b0;
            csn_prev  <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_SpiSclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_SpiMosi};
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], i_SpiCsN};
            sclk_prev <= sclk_s;
            csn_prev  <= csn_s;
        end
    end

    // Edge detection, frame assembly and FIFO handshake
    always_comb begin
        sclk_s       = sclk_sync[SYNC_STAGES-1];
        mosi_s       = mosi_sync[SYNC_STAGES-1];
        csn_s        = csn_sync[SYNC_STAGES-1];
        sclk_rise_c  = sclk_s & ~sclk_prev;
        csn_rise_c   = csn_s & ~csn_prev;
        frame_bits_c = {shift_reg, mosi_s};
        frame_c      = reg_write_t'(frame_bits_c);
        push_c       = sclk_rise_c & ~csn_s & (bit_cnt == CNT_W'(FRAME_W - 1));
        full_c       = (o_FifoLevel == LVL_W'(FIFO_DEPTH));
        pop_c        = (o_FifoLevel != '0) & ~i_WriteHold;
        // A pop in the same cycle frees the slot the push needs
        push_ok_c    = push_c & (~full_c | pop_c);
    end

    // Deserializer; CS_N high clears it, a rise mid-frame flags an error
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            bit_cnt      <= '0;
            shift_reg    <= '0;
            o_FrameError <= 1'b0;
        end else if (csn_s) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            if (csn_rise_c && (bit_cnt != '0)) begin
                o_FrameError <= 1'b1;
            end
        end else if (sclk_rise_c) begin
            shift_reg <= frame_bits_c[FRAME_W-2:0];
            bit_cnt   <= push_c ? '0 : bit_cnt + CNT_W'(1);
        end
    end

    // FIFO storage (no reset needed; validity tracked by the level)
    always_ff @(posedge i_Clock) begin
        if (push_ok_c) begin
            fifo_mem[wr_ptr] <= frame_c;
        end
    end

    // FIFO pointers, occupancy, overflow flag and drain output register
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_ptr                <= '0;
            rd_ptr                <= '0;
            o_FifoLevel           <= '0;
            o_Overflow            <= 1'b0;
            o_RegisterWriteEnable <= 1'b0;
            o_RegisterWriteNumber <= '0;
            o_RegisterWriteValue  <= '0;
        end else begin
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (push_c && !push_ok_c) begin
                o_Overflow <= 1'b1;
            end
            if (push_ok_c && !pop_c) begin
                o_FifoLevel <= o_FifoLevel + LVL_W'(1);
            end else if (!push_ok_c && pop_c) begin
                o_FifoLevel <= o_FifoLevel - LVL_W'(1);
            end
            o_RegisterWriteEnable <= pop_c;
            if (pop_c) begin
                rd_ptr                <= rd_ptr + PTR_W'(1);
                o_RegisterWriteNumber <= fifo_mem[rd_ptr].number;
                o_RegisterWriteValue  <= fifo_mem[rd_ptr].value;
            end
        end
    end

endmodule

// File: tb/tb_spi_register_loader.sv
// tb_spi_register_loader: directed self-checking bench for spi_register_loader.
// SPI is bit-banged with SCLK at i_Clock/8; a negedge monitor logs every
// write strobe and the FIFO level per cycle.
module tb_spi_register_loader;

    logic        i_Clock = 1'b0;
    logic        i_Reset;
    logic        i_SpiSclk;
    logic        i_SpiMosi;
    logic        i_SpiCsN;
    logic        i_WriteHold;
    logic        o_RegisterWriteEnable;
    logic [15:0] o_RegisterWriteNumber;
    logic [7:0]  o_RegisterWriteValue;
    logic [4:0]  o_FifoLevel;
    logic        o_Overflow;
    logic        o_FrameError;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          n_strobe = 0;
    int          raise_cyc = 0;
    logic [15:0] s_num [64];
    logic [7:0]  s_val [64];
    int          s_cyc [64];
    logic [4:0]  lvl_hist [256];

    spi_register_loader #(
        .FIFO_DEPTH (16),
        .SYNC_STAGES(2)
    ) dut (
        .i_Clock              (i_Clock),
        .i_Reset              (i_Reset),
        .i_SpiSclk            (i_SpiSclk),
        .i_SpiMosi            (i_SpiMosi),
        .i_SpiCsN             (i_SpiCsN),
        .i_WriteHold          (i_WriteHold),
        .o_RegisterWriteEnable(o_RegisterWriteEnable),
        .o_RegisterWriteNumber(o_RegisterWriteNumber),
        .o_RegisterWriteValue (o_RegisterWriteValue),
        .o_FifoLevel          (o_FifoLevel),
        .o_Overflow           (o_Overflow),
        .o_FrameError         (o_FrameError)
    );

    always #5 i_Clock = ~i_Clock;

    always @(posedge i_Clock) cyc <= cyc + 1;

    // Strobe and level logger
    always @(negedge i_Clock) begin
        lvl_hist[8'(cyc)] = o_FifoLevel;
        if (o_RegisterWriteEnable) begin
            if (n_strobe < 64) begin
                s_num[n_strobe] = o_RegisterWriteNumber;
                s_val[n_strobe] = o_RegisterWriteValue;
                s_cyc[n_strobe] = cyc;
            end
            n_strobe = n_strobe + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge i_Clock);
        i_Reset = 1'b1;
        repeat (2) @(negedge i_Clock);
        i_Reset = 1'b0;
    endtask

    // One SPI bit; with rel set, hold is released in the cycle the edge is detected
    task automatic spi_bit(input logic b, input logic rel);
        i_SpiMosi = b;
        repeat (4) @(negedge i_Clock);
        i_SpiSclk = 1'b1;
        raise_cyc = cyc;
        if (rel) begin
            repeat (2) @(negedge i_Clock);
            i_WriteHold = 1'b0;
            @(posedge i_Clock);
            #1;
            check_eq("t5_level_simul", 32'(o_FifoLevel), 32'd16);
            repeat (2) @(negedge i_Clock);
        end else begin
            repeat (4) @(negedge i_Clock);
        end
        i_SpiSclk = 1'b0;
    endtask

    task automatic spi_frame(input logic [23:0] f, input logic rel);
        for (int b = 23; b >= 0; b--) begin
            spi_bit(f[b], rel && (b == 0));
        end
    endtask

    task automatic cs_low();
        @(negedge i_Clock);
        i_SpiCsN = 1'b0;
        repeat (4) @(negedge i_Clock);
    endtask

    task automatic cs_high();
        repeat (4) @(negedge i_Clock);
        i_SpiCsN = 1'b1;
        repeat (8) @(negedge i_Clock);
    endtask

    initial begin
        i_Reset     = 1'b1;
        i_SpiSclk   = 1'b0;
        i_SpiMosi   = 1'b0;
        i_SpiCsN    = 1'b1;
        i_WriteHold = 1'b0;
        repeat (3) @(negedge i_Clock);
        i_Reset = 1'b0;
        @(posedge i_Clock);
        #1;
        check_eq("rst_en",    32'(o_RegisterWriteEnable), 32'd0);
        check_eq("rst_num",   32'(o_RegisterWriteNumber), 32'd0);
        check_eq("rst_val",   32'(o_RegisterWriteValue),  32'd0);
        check_eq("rst_level", 32'(o_FifoLevel),           32'd0);
        check_eq("rst_ovf",   32'(o_Overflow),            32'd0);
        check_eq("rst_ferr",  32'(o_FrameError),          32'd0);

        // Single frame, exact latency: 2 sync + detect + FIFO write + pop register
        n_strobe = 0;
        cs_low();
        spi_frame(24'hC005A7, 1'b0);
        cs_high();
        repeat (20) @(negedge i_Clock);
        check_eq("t1_count", 32'(n_strobe), 32'd1);
        check_eq("t1_num",   32'(s_num[0]), 32'hC005);
        check_eq("t1_val",   32'(s_val[0]), 32'hA7);
        check_eq("t1_cycle", 32'(s_cyc[0]), 32'(raise_cyc + 4));
        check_eq("t1_lvl_E",  32'(lvl_hist[8'(raise_cyc + 2)]), 32'd0);
        check_eq("t1_lvl_E1", 32'(lvl_hist[8'(raise_cyc + 3)]), 32'd1);
        check_eq("t1_lvl_E2", 32'(lvl_hist[8'(raise_cyc + 4)]), 32'd0);

        // Three streamed frames under hold, then release
        i_WriteHold = 1'b1;
        n_strobe = 0;
        cs_low();
        spi_frame(24'hC00001, 1'b0);
        spi_frame(24'hC10002, 1'b0);
        spi_frame(24'h800103, 1'b0);
        cs_high();
        repeat (10) @(negedge i_Clock);
        check_eq("t2_level_held", 32'(o_FifoLevel), 32'd3);
        check_eq("t2_no_strobe",  32'(n_strobe),    32'd0);
        i_WriteHold = 1'b0;
        repeat (20) @(negedge i_Clock);
        check_eq("t2_count", 32'(n_strobe), 32'd3);
        check_eq("t2_num0", 32'(s_num[0]), 32'hC000);
        check_eq("t2_val0", 32'(s_val[0]), 32'h01);
        check_eq("t2_num1", 32'(s_num[1]), 32'hC100);
        check_eq("t2_val1", 32'(s_val[1]), 32'h02);
        check_eq("t2_num2", 32'(s_num[2]), 32'h8001);
        check_eq("t2_val2", 32'(s_val[2]), 32'h03);
        check_eq("t2_b2b1", 32'(s_cyc[1]), 32'(s_cyc[0] + 1));
        check_eq("t2_b2b2", 32'(s_cyc[2]), 32'(s_cyc[0] + 2));
        check_eq("t2_level_end", 32'(o_FifoLevel), 32'd0);

        // Partial frame abort (13 bits), then a valid frame
        n_strobe = 0;
        cs_low();
        for (int b = 0; b < 13; b++) spi_bit(1'b1, 1'b0);
        cs_high();
        repeat (10) @(negedge i_Clock);
        check_eq("t3_ferr",   32'(o_FrameError), 32'd1);
        check_eq("t3_level",  32'(o_FifoLevel),  32'd0);
        check_eq("t3_nostrb", 32'(n_strobe),     32'd0);
        cs_low();
        spi_frame(24'h123456, 1'b0);
        cs_high();
        repeat (20) @(negedge i_Clock);
        check_eq("t3_count", 32'(n_strobe), 32'd1);
        check_eq("t3_num",   32'(s_num[0]), 32'h1234);
        check_eq("t3_val",   32'(s_val[0]), 32'h56);

        // Overflow: 17 frames into 16 entries under hold
        do_reset();
        i_WriteHold = 1'b1;
        n_strobe = 0;
        cs_low();
        for (int i = 1; i <= 17; i++) spi_frame({16'h1000 + 16'(i), 8'(i)}, 1'b0);
        cs_high();
        repeat (10) @(negedge i_Clock);
        check_eq("t4_level", 32'(o_FifoLevel), 32'd16);
        check_eq("t4_ovf",   32'(o_Overflow),  32'd1);
        check_eq("t4_nostrb", 32'(n_strobe),   32'd0);
        i_WriteHold = 1'b0;
        repeat (40) @(negedge i_Clock);
        check_eq("t4_count", 32'(n_strobe), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("t4_num%0d", i), 32'(s_num[i]), 32'(16'h1000 + 16'(i + 1)));
            check_eq($sformatf("t4_val%0d", i), 32'(s_val[i]), 32'(i + 1));
        end

        // Push into a full FIFO in the same cycle as the first pop
        do_reset();
        i_WriteHold = 1'b1;
        n_strobe = 0;
        cs_low();
        for (int i = 1; i <= 16; i++) spi_frame({16'h2000 + 16'(i), 8'h40 + 8'(i)}, 1'b0);
        spi_frame(24'h201151, 1'b1);
        cs_high();
        repeat (40) @(negedge i_Clock);
        check_eq("t5_ovf",    32'(o_Overflow),  32'd0);
        check_eq("t5_count",  32'(n_strobe),    32'd17);
        check_eq("t5_num1",   32'(s_num[0]),    32'h2001);
        check_eq("t5_num17",  32'(s_num[16]),   32'h2011);
        check_eq("t5_val17",  32'(s_val[16]),   32'h51);
        check_eq("t5_level",  32'(o_FifoLevel), 32'd0);

        // Reset with 5 entries queued and 10 bits shifted in
        do_reset();
        i_WriteHold = 1'b1;
        cs_low();
        for (int i = 1; i <= 5; i++) spi_frame({16'h3000 + 16'(i), 8'(i)}, 1'b0);
        for (int b = 0; b < 10; b++) spi_bit(b[0], 1'b0);
        check_eq("t6_level_pre", 32'(o_FifoLevel), 32'd5);
        @(negedge i_Clock);
        i_Reset     = 1'b1;
        i_WriteHold = 1'b0;
        @(posedge i_Clock);
        #1;
        check_eq("t6_en",    32'(o_RegisterWriteEnable), 32'd0);
        check_eq("t6_num",   32'(o_RegisterWriteNumber), 32'd0);
        check_eq("t6_val",   32'(o_RegisterWriteValue),  32'd0);
        check_eq("t6_level", 32'(o_FifoLevel),           32'd0);
        check_eq("t6_ovf",   32'(o_Overflow),            32'd0);
        check_eq("t6_ferr",  32'(o_FrameError),          32'd0);
        @(negedge i_Clock);
        i_Reset = 1'b0;
        n_strobe = 0;
        @(posedge i_Clock);
        #1;
        check_eq("t6_en_after", 32'(o_RegisterWriteEnable), 32'd0);
        cs_high();
        cs_low();
        spi_frame(24'hABCD5A, 1'b0);
        cs_high();
        repeat (20) @(negedge i_Clock);
        check_eq("t6_count",    32'(n_strobe),     32'd1);
        check_eq("t6_num_new",  32'(s_num[0]),     32'hABCD);
        check_eq("t6_val_new",  32'(s_val[0]),     32'h5A);
        check_eq("t6_ferr_end", 32'(o_FrameError), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
